seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Receive side of the multiplexed 6-digit 7-segment display bus. Watches the scanned
//   seg_sel_n/seg_data pins and rebuilds the 24-bit BCD value, blank mask and point bits
//   that were driven into the display driver. Used as an on-chip readback monitor and
//   loop-back checker for display traffic. Publishes a frame only after it has been
//   stable for several scan frames.
// PARAMETERS
//   SETTLE_CYC    default 1000  cycles a select must stay unchanged before its digit is sampled (>=2)
//   STABLE_FRAMES default 2     consecutive identical complete frames required before publish (>=1)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   seg_sel_n  in   6   digit select, active-low one-hot; bit0 = rightmost digit
//   seg_data   in   8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   dout       out  24  decoded BCD/hex; dout[4i+3:4i] = digit i
//   dout_mask  out  6   1 = digit i lit, 0 = digit i blank
//   point_n    out  6   0 = decimal point of digit i lit
//   dout_vld   out  1   one-cycle pulse when dout/dout_mask/point_n update
//   pat_err    out  1   one-cycle pulse on an undecodable pattern or illegal select
// BEHAVIOUR
//   Reset: dout=0, dout_mask=0, point_n=6'h3F, dout_vld=0, pat_err=0; FSM->IDLE, frame
//     bitmap cleared, stable counter 0. Reset mid-frame discards the partial frame.
//   Inputs registered twice before use (2-cycle input latency); all logic on the 2nd stage.
//   Select classes: one-hot-low = valid; 6'h3F = idle; anything else = illegal.
//   FSM:
//     IDLE    : valid select -> SETTLE (counter=0). Illegal -> pat_err pulse, stay.
//     SETTLE  : select or seg_data changes -> restart counter (same state); select goes
//               idle -> IDLE; illegal -> pat_err, IDLE. Counter reaching SETTLE_CYC-1 ->
//               sample digit into frame slot, set bitmap bit -> HOLD.
//     HOLD    : wait; select change to another valid digit -> SETTLE; idle -> IDLE;
//               illegal -> pat_err, IDLE. Same select re-entered after change re-samples.
//   Digit decode (seg_data[6:0]): 0-9 per standard table; 7'h7F -> mask 0, code 4'h0;
//     unknown pattern -> code 4'hF, mask 1, pat_err pulse on sample cycle, frame marked bad.
//     dp = seg_data[7] copied to point slot.
//   Frame: bitmap == 6'h3F closes frame (at the sample cycle of the last missing digit);
//     bitmap cleared same cycle. Bad frame -> stable counter 0, no compare.
//     Good frame equal to previous good frame -> stable counter +1 (saturating), else 1.
//     Counter reaching STABLE_FRAMES and frame differs from current dout/mask/point ->
//     outputs update and dout_vld pulses one cycle later. Identical re-publish suppressed.
//   Re-sampling a slot already in the bitmap overwrites it (out-of-order scan tolerated).
//   pat_err and dout_vld may assert in the same cycle; independent.
// CONFIGURATION
//   SEG_DEC_HEX_EN defined : patterns A,b,C,d,E,F decode to 4'hA-4'hF, no error.
//   SEG_DEC_HEX_EN undefined: those patterns are unknown -> 4'hF + pat_err + bad frame.
// STRUCTURE
//   Package seg_dec_pkg: 7-seg pattern constants (SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK
//     = 7'h7F), FSM state typedef {IDLE,SETTLE,HOLD}, DIGITS=6 constant.
//   Sub-module seg_pattern_lut: combinational 7-bit pattern -> {code[3:0], lit, unknown};
//     contains the SEG_DEC_HEX_EN conditional. Counter width $clog2(SETTLE_CYC).
// TESTING
//   Scan 10.23.56 (points on digits 4,2), SETTLE_CYC=8, 2 frames -> dout=24'h102356,
//     dout_mask=6'h3F, point_n=6'b101011, one dout_vld after 2nd frame close.
//   Same frame scanned 5 more times -> no further dout_vld.
//   Digit 5 = 7'h7F -> dout_mask=6'h1F, dout[23:20]=0.
//   Glitch: select toggles after 3 cycles in SETTLE -> no sample; frame completes only after
//     full settle; seg_sel_n=6'h3C -> pat_err pulse, FSM IDLE.
//   Pattern E (7'h06) on digit 0: without SEG_DEC_HEX_EN -> pat_err, no publish; with it ->
//     dout[3:0]=4'hE published after 2 frames.
//   rst asserted mid-frame after 3 digits -> outputs to reset values; next publish needs
//     2 fresh complete frames.

Source files
------------

// File: rtl/seg_dec_pkg.sv
// seg_dec_pkg: shared constants and types for the 7-segment scan decoder.
// Segment patterns are active-low in the order {g,f,e,d,c,b,a}.
package seg_dec_pkg;

  localparam int DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_e;

  // Index of the (single) low bit of an active-low one-hot select.
  function automatic logic [2:0] sel_to_idx(input logic [5:0] sel_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!sel_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_dec_pattern_lut.sv
// seg_pattern_lut: combinational 7-segment pattern to digit-code lookup.
// SEG_DEC_HEX_EN: when defined, the letters A,b,C,d,E,F decode to 4'hA-4'hF;
// otherwise they are treated as unknown patterns.
module seg_pattern_lut
  import seg_dec_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code,
  output logic       o_lit,
  output logic       o_unknown
);

  // Pattern decode; anything not listed is reported as unknown with code F.
  always_comb begin
    o_code    = 4'hF;
    o_lit     = 1'b1;
    o_unknown = 1'b1;
    case (i_pat)
      SEG_0:     begin o_code = 4'h0; o_unknown = 1'b0; end
      SEG_1:     begin o_code = 4'h1; o_unknown = 1'b0; end
      SEG_2:     begin o_code = 4'h2; o_unknown = 1'b0; end
      SEG_3:     begin o_code = 4'h3; o_unknown = 1'b0; end
      SEG_4:     begin o_code = 4'h4; o_unknown = 1'b0; end
      SEG_5:     begin o_code = 4'h5; o_unknown = 1'b0; end
      SEG_6:     begin o_code = 4'h6; o_unknown = 1'b0; end
      SEG_7:     begin o_code = 4'h7; o_unknown = 1'b0; end
      SEG_8:     begin o_code = 4'h8; o_unknown = 1'b0; end
      SEG_9:     begin o_code = 4'h9; o_unknown = 1'b0; end
      SEG_BLANK: begin o_code = 4'h0; o_lit = 1'b0; o_unknown = 1'b0; end
`ifdef SEG_DEC_HEX_EN
      SEG_A:     begin o_code = 4'hA; o_unknown = 1'b0; end
      SEG_B:     begin o_code = 4'hB; o_unknown = 1'b0; end
      SEG_C:     begin o_code = 4'hC; o_unknown = 1'b0; end
      SEG_D:     begin o_code = 4'hD; o_unknown = 1'b0; end
      SEG_E:     begin o_code = 4'hE; o_unknown = 1'b0; end
      SEG_F:     begin o_code = 4'hF; o_unknown = 1'b0; end
`endif
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the BCD value, blank mask and decimal points from
// the scanned 6-digit 7-segment bus and publishes a frame once it has repeated
// STABLE_FRAMES times. Hex-letter decode is enabled by defining SEG_DEC_HEX_EN.
module seg_scan_decoder
  import seg_dec_pkg::*;
#(
  parameter int SETTLE_CYC    = 1000,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_sel_n,
  input  logic [7:0]  seg_data,
  output logic [23:0] dout,
  output logic [5:0]  dout_mask,
  output logic [5:0]  point_n,
  output logic        dout_vld,
  output logic        pat_err
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STB_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0] STB_TGT  = STB_W'(STABLE_FRAMES);

  // Stable-frame counter increment that sticks at the publish threshold.
  function automatic logic [STB_W-1:0] stb_sat_inc(input logic [STB_W-1:0] v);
    return (v >= STB_TGT) ? v : v + STB_W'(1);
  endfunction

  logic [5:0]       r_sel_p0, r_sel_p1;
  logic [7:0]       r_seg_p0, r_seg_p1;
  logic [5:0]       r_cur_sel;
  logic [7:0]       r_cur_seg;
  seg_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_fr_code;
  logic [5:0]       r_fr_lit, r_fr_pt, r_bitmap;
  logic             r_fr_bad, r_prev_vld;
  logic [35:0]      r_prev;
  logic [STB_W-1:0] r_stb;

  logic             w_sel_idle, w_sel_valid, w_sel_ill, w_sel_chg, w_seg_chg;
  logic [2:0]       w_idx;
  logic             w_start, w_sample, w_ill_err;
  logic [3:0]       w_code;
  logic             w_lit, w_unk;
  logic [23:0]      w_fr_code;
  logic [5:0]       w_fr_lit, w_fr_pt, w_bitmap_nx;
  logic [35:0]      w_frame;
  logic             w_close, w_bad, w_same_prev, w_pub;
  logic [STB_W-1:0] w_stb_nx;

  // Stage p0 -> p1: two-flop capture of the select pins (idle after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_p0 <= 6'h3F;
      r_sel_p1 <= 6'h3F;
    end else begin
      r_sel_p0 <= seg_sel_n;
      r_sel_p1 <= r_sel_p0;
    end
  end

  // Stage p0 -> p1: two-flop capture of the segment pins.
  always_ff @(posedge clk) begin
    r_seg_p0 <= seg_data;
    r_seg_p1 <= r_seg_p0;
  end

  assign w_sel_idle  = (r_sel_p1 == 6'h3F);
  assign w_sel_valid = $onehot(~r_sel_p1);
  assign w_sel_ill   = !w_sel_idle && !w_sel_valid;
  assign w_sel_chg   = (r_sel_p1 != r_cur_sel);
  assign w_seg_chg   = (r_seg_p1 != r_cur_seg);
  assign w_idx       = sel_to_idx(r_sel_p1);

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Scan FSM next state: settle timing restart, digit sample and select errors.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_sample   = 1'b0;
    w_ill_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_state_nx = SETTLE;
          w_start    = 1'b1;
        end else if (w_sel_ill) begin
          w_ill_err = 1'b1;
        end
      end
      SETTLE: begin
        if (w_sel_idle) begin
          w_state_nx = IDLE;
        end else if (w_sel_ill) begin
          w_ill_err  = 1'b1;
          w_state_nx = IDLE;
        end else if (w_sel_chg || w_seg_chg) begin
          w_start = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_sample   = 1'b1;
          w_state_nx = HOLD;
        end
      end
      HOLD: begin
        if (w_sel_idle) begin
          w_state_nx = IDLE;
        end else if (w_sel_ill) begin
          w_ill_err  = 1'b1;
          w_state_nx = IDLE;
        end else if (w_sel_chg) begin
          w_state_nx = SETTLE;
          w_start    = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Settle counter: restarts on every select/data change, counts while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cur_sel <= 6'h3F;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_cur_sel <= r_sel_p1;
    end else if (r_state == SETTLE && r_cnt != CNT_LAST) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Segment value the settle counter is timing against.
  always_ff @(posedge clk) begin
    if (w_start) r_cur_seg <= r_seg_p1;
  end

  seg_pattern_lut u_lut (
    .i_pat     (r_seg_p1[6:0]),
    .o_code    (w_code),
    .o_lit     (w_lit),
    .o_unknown (w_unk)
  );

  // Frame image including the digit being sampled this cycle.
  always_comb begin
    w_fr_code   = r_fr_code;
    w_fr_lit    = r_fr_lit;
    w_fr_pt     = r_fr_pt;
    w_bitmap_nx = r_bitmap;
    if (w_sample) begin
      w_fr_code[{w_idx, 2'b00} +: 4] = w_code;
      w_fr_lit[w_idx]                = w_lit;
      w_fr_pt[w_idx]                 = r_seg_p1[7];
      w_bitmap_nx[w_idx]             = 1'b1;
    end
  end

  assign w_frame     = {w_fr_code, w_fr_lit, w_fr_pt};
  assign w_close     = w_sample && (w_bitmap_nx == 6'h3F);
  assign w_bad       = r_fr_bad || (w_sample && w_unk);
  assign w_same_prev = r_prev_vld && (w_frame == r_prev);
  assign w_stb_nx    = w_bad ? '0 : (w_same_prev ? stb_sat_inc(r_stb) : STB_W'(1));
  assign w_pub       = w_close && !w_bad && (w_stb_nx >= STB_TGT) &&
                       (w_frame != {dout, dout_mask, point_n});

  // Frame bookkeeping, stability tracking and published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitmap   <= '0;
      r_fr_bad   <= 1'b0;
      r_stb      <= '0;
      r_prev_vld <= 1'b0;
      dout       <= '0;
      dout_mask  <= '0;
      point_n    <= 6'h3F;
      dout_vld   <= 1'b0;
      pat_err    <= 1'b0;
    end else begin
      dout_vld <= w_pub;
      pat_err  <= w_ill_err || (w_sample && w_unk);
      if (w_close) begin
        r_bitmap <= '0;
        r_fr_bad <= 1'b0;
        r_stb    <= w_stb_nx;
        if (!w_bad) r_prev_vld <= 1'b1;
      end else if (w_sample) begin
        r_bitmap <= w_bitmap_nx;
        r_fr_bad <= w_bad;
      end
      if (w_pub) begin
        dout      <= w_fr_code;
        dout_mask <= w_fr_lit;
        point_n   <= w_fr_pt;
      end
    end
  end

  // Frame slot storage and the last good frame used for the repeat check.
  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_fr_code <= w_fr_code;
      r_fr_lit  <= w_fr_lit;
      r_fr_pt   <= w_fr_pt;
    end
    if (w_close && !w_bad) r_prev <= w_frame;
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for seg_scan_decoder (SETTLE_CYC=8,
// STABLE_FRAMES=2). Expectations for the letter patterns follow SEG_DEC_HEX_EN.
module tb_seg_scan_decoder;

  localparam int SETTLE   = 8;
  localparam int STABLE   = 2;
  localparam int HOLD_CYC = 14;

  // Frames packed as {digit5,...,digit0}, each byte {dp_n, g..a} active-low.
  localparam logic [47:0] F_MAIN  = 48'hF9_40_A4_30_92_82; // 10.23.56
  localparam logic [47:0] F_BLANK = 48'hFF_40_A4_30_92_82; // blank 0.23.56
  localparam logic [47:0] F_X     = 48'h82_92_99_B0_A4_F9; // 654321
  localparam logic [47:0] F_HEX   = 48'hF9_A4_B0_99_92_86; // 12345E

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  seg_sel_n;
  logic [7:0]  seg_data;
  logic [23:0] dout;
  logic [5:0]  dout_mask;
  logic [5:0]  point_n;
  logic        dout_vld;
  logic        pat_err;

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  m;
    logic [5:0]  p;
  } pub_t;

  pub_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_vld = 0;
  int   n_perr = 0;

  // model state
  int   m_stb;
  logic m_prev_vld;
  pub_t m_prev;
  pub_t m_pub;

  seg_scan_decoder #(.SETTLE_CYC(SETTLE), .STABLE_FRAMES(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_sel_n (seg_sel_n),
    .seg_data  (seg_data),
    .dout      (dout),
    .dout_mask (dout_mask),
    .point_n   (point_n),
    .dout_vld  (dout_vld),
    .pat_err   (pat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got hang want finish");
    $fatal(1, "timeout");
  end

  // Output monitor: counts error pulses and checks each publish against the scoreboard.
  always @(negedge clk) begin
    pub_t e;
    if (!rst && pat_err) n_perr++;
    if (!rst && dout_vld) begin
      n_vld++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_publish got dout=%h mask=%h pt=%h want no publish",
                 dout, dout_mask, point_n);
      end else begin
        e = exp_q.pop_front();
        if ({dout, dout_mask, point_n} !== e)
          $display("FAIL publish_value got %h/%h/%h want %h/%h/%h",
                   dout, dout_mask, point_n, e.d, e.m, e.p);
        else
          n_pass++;
      end
    end
  end

  // Reference 7-segment decode: {code, lit, unknown}.
  function automatic logic [5:0] ref_dec(input logic [6:0] p);
    case (p)
      7'h40: return {4'h0, 2'b10};
      7'h79: return {4'h1, 2'b10};
      7'h24: return {4'h2, 2'b10};
      7'h30: return {4'h3, 2'b10};
      7'h19: return {4'h4, 2'b10};
      7'h12: return {4'h5, 2'b10};
      7'h02: return {4'h6, 2'b10};
      7'h78: return {4'h7, 2'b10};
      7'h00: return {4'h8, 2'b10};
      7'h10: return {4'h9, 2'b10};
      7'h7F: return {4'h0, 2'b00};
`ifdef SEG_DEC_HEX_EN
      7'h08: return {4'hA, 2'b10};
      7'h03: return {4'hB, 2'b10};
      7'h46: return {4'hC, 2'b10};
      7'h21: return {4'hD, 2'b10};
      7'h06: return {4'hE, 2'b10};
      7'h0E: return {4'hF, 2'b10};
`endif
      default: return {4'hF, 2'b11};
    endcase
  endfunction

  task automatic model_reset();
    m_stb      = 0;
    m_prev_vld = 1'b0;
    m_prev     = '0;
    m_pub      = {24'h0, 6'h00, 6'h3F};
  endtask

  // Frame-level model of the stability/publish rule; pushes an expected publish.
  task automatic model_frame(input logic [47:0] f);
    pub_t       fr;
    logic       bad;
    logic [5:0] r;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = ref_dec(f[8*i +: 7]);
      fr.d[4*i +: 4] = r[5:2];
      fr.m[i]        = r[1];
      fr.p[i]        = f[8*i+7];
      bad            = bad | r[0];
    end
    if (bad) begin
      m_stb = 0;
    end else begin
      if (m_prev_vld && fr == m_prev) m_stb = (m_stb < STABLE) ? m_stb + 1 : m_stb;
      else m_stb = 1;
      m_prev     = fr;
      m_prev_vld = 1'b1;
      if (m_stb >= STABLE && fr != m_pub) begin
        exp_q.push_back(fr);
        m_pub = fr;
      end
    end
  endtask

  task automatic drive(input logic [5:0] sel, input logic [7:0] seg, input int n);
    seg_sel_n = sel;
    seg_data  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int idx, input logic [7:0] seg, input int n);
    logic [5:0] s;
    s = 6'b000001 << idx;
    drive(~s, seg, n);
  endtask

  task automatic scan_frame(input logic [47:0] f);
    model_frame(f);
    for (int i = 5; i >= 0; i--) drive_digit(i, f[8*i +: 8], HOLD_CYC);
    drive(6'h3F, 8'hFF, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(6'h3F, 8'hFF, 3);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'h3F, 8'hFF, 3);
    @(negedge clk);
    n_total++; if (dout !== 24'h0) $display("FAIL reset_dout got %h want %h", dout, 24'h0); else n_pass++;
    n_total++; if (dout_mask !== 6'h00) $display("FAIL reset_mask got %h want %h", dout_mask, 6'h00); else n_pass++;
    n_total++; if (point_n !== 6'h3F) $display("FAIL reset_point got %h want %h", point_n, 6'h3F); else n_pass++;
    n_total++; if (dout_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", dout_vld); else n_pass++;
    n_total++; if (pat_err !== 1'b0) $display("FAIL reset_perr got %b want 0", pat_err); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int v0;
    do_reset();
    v0 = n_vld;
    scan_frame(F_MAIN);
    n_total++; if (n_vld !== v0) $display("FAIL basic_one_frame vld_count got %0d want %0d", n_vld, v0); else n_pass++;
    scan_frame(F_MAIN);
    n_total++; if (n_vld !== v0 + 1) $display("FAIL basic_two_frames vld_count got %0d want %0d", n_vld, v0 + 1); else n_pass++;
    n_total++; if (dout !== 24'h102356) $display("FAIL basic_dout got %h want %h", dout, 24'h102356); else n_pass++;
    n_total++; if (dout_mask !== 6'h3F) $display("FAIL basic_mask got %h want %h", dout_mask, 6'h3F); else n_pass++;
    n_total++; if (point_n !== 6'b101011) $display("FAIL basic_point got %b want %b", point_n, 6'b101011); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_vld;
    repeat (5) scan_frame(F_MAIN);
    n_total++; if (n_vld !== v0) $display("FAIL repeat_suppressed vld_count got %0d want %0d", n_vld, v0); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL repeat_queue got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_blank();
    scan_frame(F_BLANK);
    scan_frame(F_BLANK);
    n_total++; if (dout_mask !== 6'h1F) $display("FAIL blank_mask got %h want %h", dout_mask, 6'h1F); else n_pass++;
    n_total++; if (dout !== 24'h002356) $display("FAIL blank_dout got %h want %h", dout, 24'h002356); else n_pass++;
  endtask

  task automatic test_glitch();
    int v0, pe0;
    do_reset();
    v0 = n_vld;
    pe0 = n_perr;
    drive_digit(5, F_X[47:40], HOLD_CYC);
    drive_digit(4, F_X[39:32], HOLD_CYC);
    drive_digit(3, F_X[31:24], 4);
    drive_digit(2, F_X[23:16], HOLD_CYC);
    drive_digit(1, F_X[15:8], HOLD_CYC);
    drive_digit(0, F_X[7:0], HOLD_CYC);
    drive(6'h3F, 8'hFF, 4);
    scan_frame(F_X);
    n_total++; if (n_vld !== v0) $display("FAIL glitch_no_early_publish vld_count got %0d want %0d", n_vld, v0); else n_pass++;
    scan_frame(F_X);
    n_total++; if (n_vld !== v0 + 1) $display("FAIL glitch_publish vld_count got %0d want %0d", n_vld, v0 + 1); else n_pass++;
    n_total++; if (dout !== 24'h654321) $display("FAIL glitch_dout got %h want %h", dout, 24'h654321); else n_pass++;
    n_total++; if (n_perr !== pe0) $display("FAIL glitch_no_err pat_err_count got %0d want %0d", n_perr, pe0); else n_pass++;
    pe0 = n_perr;
    drive(6'h3C, 8'hFF, 1);
    drive(6'h3F, 8'hFF, 4);
    n_total++; if (n_perr !== pe0 + 1) $display("FAIL illegal_sel pat_err_count got %0d want %0d", n_perr, pe0 + 1); else n_pass++;
  endtask

  task automatic test_hex();
    int v0, pe0;
    do_reset();
    v0 = n_vld;
    pe0 = n_perr;
    scan_frame(F_HEX);
    scan_frame(F_HEX);
`ifdef SEG_DEC_HEX_EN
    n_total++; if (n_vld !== v0 + 1) $display("FAIL hex_publish vld_count got %0d want %0d", n_vld, v0 + 1); else n_pass++;
    n_total++; if (dout[3:0] !== 4'hE) $display("FAIL hex_digit0 got %h want %h", dout[3:0], 4'hE); else n_pass++;
    n_total++; if (n_perr !== pe0) $display("FAIL hex_no_err pat_err_count got %0d want %0d", n_perr, pe0); else n_pass++;
`else
    n_total++; if (n_vld !== v0) $display("FAIL hex_no_publish vld_count got %0d want %0d", n_vld, v0); else n_pass++;
    n_total++; if (dout !== 24'h0) $display("FAIL hex_dout_held got %h want %h", dout, 24'h0); else n_pass++;
    n_total++; if (n_perr !== pe0 + 2) $display("FAIL hex_err pat_err_count got %0d want %0d", n_perr, pe0 + 2); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    scan_frame(F_MAIN);
    scan_frame(F_MAIN);
    n_total++; if (dout !== 24'h102356) $display("FAIL midrst_pre_dout got %h want %h", dout, 24'h102356); else n_pass++;
    drive_digit(5, F_MAIN[47:40], HOLD_CYC);
    drive_digit(4, F_MAIN[39:32], HOLD_CYC);
    drive_digit(3, F_MAIN[31:24], HOLD_CYC);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (dout !== 24'h0) $display("FAIL midrst_dout got %h want %h", dout, 24'h0); else n_pass++;
    n_total++; if (dout_mask !== 6'h00) $display("FAIL midrst_mask got %h want %h", dout_mask, 6'h00); else n_pass++;
    n_total++; if (point_n !== 6'h3F) $display("FAIL midrst_point got %h want %h", point_n, 6'h3F); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(6'h3F, 8'hFF, 4);
    v0 = n_vld;
    scan_frame(F_MAIN);
    n_total++; if (n_vld !== v0) $display("FAIL midrst_one_frame vld_count got %0d want %0d", n_vld, v0); else n_pass++;
    scan_frame(F_MAIN);
    n_total++; if (n_vld !== v0 + 1) $display("FAIL midrst_two_frames vld_count got %0d want %0d", n_vld, v0 + 1); else n_pass++;
    n_total++; if (dout !== 24'h102356) $display("FAIL midrst_dout_after got %h want %h", dout, 24'h102356); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    seg_sel_n = 6'h3F;
    seg_data  = 8'hFF;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_blank();
    test_glitch();
    test_hex();
    test_reset_mid();
    drive(6'h3F, 8'hFF, 5);
    n_total++; if (exp_q.size() !== 0) $display("FAIL final_queue pending got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
